mips_cpu_harvard: RTL and testbench

//  Single-cycle MIPS32 subset CPU, Harvard memory interface: separate instruction port and data port.

---
 rtl/mips_pkg.sv | 75 +++++++
 rtl/mips_cpu_harvard_regfile.sv | 32 +++
 rtl/mips_cpu_harvard.sv | 195 +++++++++++++++++++
 tb/tb_mips_cpu_harvard.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcodes, function codes and ALU operations for the MIPS32 subset core.
// Also holds the default reset vector and the ALU helper used by the core.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_op_t;

  // Shifts and LUI operate on b; a is the rs operand.
  function automatic logic [31:0] alu(
    input alu_op_t     op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  sh
  );
    logic [31:0] y;
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_SLL:  y = b << sh;
      ALU_SRL:  y = b >> sh;
      ALU_SRA:  y = $unsigned($signed(b) >>> sh);
      ALU_LUI:  y = {b[15:0], 16'h0000};
      default:  y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mips_cpu_harvard_regfile.sv
// 32x32 general-purpose register file: two async read ports, one sync write.
// $0 is never written; the whole file clears on reset.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] v0
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
  assign v0  = regs[2];

endmodule

// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS32 subset core with separate instruction and data ports.
// Branches use one delay slot; the core halts once the PC reaches zero.
module mips_cpu_harvard
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  logic [31:0] pc;
  logic [31:0] br_target;
  logic        br_pending;
  logic        active_q;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic [31:0] br_addr;
  logic [31:0] j_addr;
  logic [31:0] pc_next;

  alu_op_t     alu_op;
  logic [31:0] opb;
  logic [31:0] alu_y;
  logic [31:0] wd;
  logic [4:0]  wa;
  logic        reg_we;
  logic        wb_link;
  logic        is_lw;
  logic        is_sw;
  logic        take;
  logic [31:0] tgt;
  logic        en;

  assign op    = instr_readdata[31:26];
  assign rs    = instr_readdata[25:21];
  assign rt    = instr_readdata[20:16];
  assign rd    = instr_readdata[15:11];
  assign shamt = instr_readdata[10:6];
  assign funct = instr_readdata[5:0];
  assign imm   = instr_readdata[15:0];

  assign sext     = {{16{imm[15]}}, imm};
  assign zext     = {16'h0000, imm};
  assign pc_plus4 = pc + 32'd4;
  assign pc_plus8 = pc + 32'd8;
  assign br_addr  = pc_plus4 + {sext[29:0], 2'b00};
  assign j_addr   = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};

  assign en = clk_enable & active_q;

  mips_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_val),
    .rd2   (rt_val),
    .we    (reg_we & en),
    .wa    (wa),
    .wd    (wd),
    .v0    (register_v0)
  );

  always_comb begin
    alu_op  = ALU_ADD;
    opb     = rt_val;
    wa      = rt;
    reg_we  = 1'b0;
    wb_link = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    take    = 1'b0;
    tgt     = br_addr;
    case (op)
      OP_SPECIAL: begin
        wa     = rd;
        reg_we = 1'b1;
        case (funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_JR: begin
            reg_we = 1'b0;
            take   = 1'b1;
            tgt    = rs_val;
          end
          FN_JALR: begin
            wb_link = 1'b1;
            take    = 1'b1;
            tgt     = rs_val;
          end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDIU: begin reg_we = 1'b1; opb = sext; end
      OP_SLTI: begin
        reg_we = 1'b1; opb = sext; alu_op = ALU_SLT;
      end
      OP_SLTIU: begin
        reg_we = 1'b1; opb = sext; alu_op = ALU_SLTU;
      end
      OP_ANDI: begin
        reg_we = 1'b1; opb = zext; alu_op = ALU_AND;
      end
      OP_ORI: begin
        reg_we = 1'b1; opb = zext; alu_op = ALU_OR;
      end
      OP_XORI: begin
        reg_we = 1'b1; opb = zext; alu_op = ALU_XOR;
      end
      OP_LUI: begin
        reg_we = 1'b1; opb = zext; alu_op = ALU_LUI;
      end
      OP_LW:  begin reg_we = 1'b1; is_lw = 1'b1; end
      OP_SW:  is_sw = 1'b1;
      OP_BEQ: take = (rs_val == rt_val);
      OP_BNE: take = (rs_val != rt_val);
      OP_J: begin take = 1'b1; tgt = j_addr; end
      OP_JAL: begin
        take    = 1'b1;
        tgt     = j_addr;
        reg_we  = 1'b1;
        wa      = 5'd31;
        wb_link = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_y = alu(alu_op, rs_val, opb, shamt);

  always_comb begin
    unique case (1'b1)
      wb_link: wd = pc_plus8;
      is_lw:   wd = data_readdata;
      default: wd = alu_y;
    endcase
  end

  // A latched target only takes effect after the delay slot has issued.
  assign pc_next = br_pending ? br_target : pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      br_pending <= 1'b0;
      br_target  <= '0;
      active_q   <= 1'b1;
    end else if (en) begin
      pc         <= pc_next;
      br_pending <= take;
      br_target  <= tgt;
      if (pc_next == 32'h0) active_q <= 1'b0;
    end
  end

  assign active         = active_q;
  assign instr_address  = pc;
  assign data_address   = rs_val + sext;
  assign data_writedata = rt_val;
  assign data_read      = is_lw & active_q;
  assign data_write     = is_sw & active_q & clk_enable;

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// Bench for mips_cpu_harvard: directed programs plus random programs checked
// cycle by cycle against an instruction-level model using a PC/next-PC pair.
module tb_mips_cpu_harvard;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  localparam logic [5:0] SPECIAL = 6'h00, J = 6'h02, JAL = 6'h03;
  localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, ADDIU = 6'h09;
  localparam logic [5:0] SLTI = 6'h0A, SLTIU = 6'h0B, ANDI = 6'h0C;
  localparam logic [5:0] ORI = 6'h0D, XORI = 6'h0E, LUI = 6'h0F;
  localparam logic [5:0] LW = 6'h23, SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
  localparam logic [5:0] F_JR = 6'h08, F_JALR = 6'h09, F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  logic        clk;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;
  logic        clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  logic [31:0] rom [64];
  logic [31:0] ram [64];

  logic [31:0] m_gpr [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;
  logic [31:0] m_npc;
  logic        m_halt;

  int n_chk;
  int n_fail;

  mips_cpu_harvard dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .register_v0    (register_v0),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_rd(input logic [31:0] a);
    if (a[31:8] == 24'hBFC000) return rom[a[7:2]];
    return 32'h0;
  endfunction

  assign instr_readdata = rom_rd(instr_address);
  assign data_readdata  = ram[data_address[7:2]];

  always @(posedge clk)
    if (data_write) ram[data_address[7:2]] <= data_writedata;

  function automatic logic [31:0] ri(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
    input logic [5:0] fn);
    return {SPECIAL, rs, rt, rd, sh, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
    input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_pc   = RV;
    m_npc  = RV + 32'd4;
    m_halt = 1'b0;
  endtask

  // Architectural step: execute at pc, then pc <= npc, npc <= successor.
  task automatic model_step();
    logic [31:0] ins, a, b, se, ze, ea, nn, res, p4;
    logic [4:0]  wi;
    logic        wr;
    ins = rom_rd(m_pc);
    a   = m_gpr[ins[25:21]];
    b   = m_gpr[ins[20:16]];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0, ins[15:0]};
    ea  = a + se;
    p4  = m_pc + 32'd4;
    nn  = m_npc + 32'd4;
    wr  = 1'b0;
    wi  = ins[20:16];
    res = '0;
    case (ins[31:26])
      SPECIAL: begin
        wi = ins[15:11];
        wr = 1'b1;
        case (ins[5:0])
          F_ADDU: res = a + b;
          F_SUBU: res = a - b;
          F_AND:  res = a & b;
          F_OR:   res = a | b;
          F_XOR:  res = a ^ b;
          F_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          F_SLTU: res = (a < b) ? 32'd1 : 32'd0;
          F_SLL:  res = b << ins[10:6];
          F_SRL:  res = b >> ins[10:6];
          F_SRA:  res = $unsigned($signed(b) >>> ins[10:6]);
          F_JR:   begin wr = 1'b0; nn = a; end
          F_JALR: begin res = m_pc + 32'd8; nn = a; end
          default: wr = 1'b0;
        endcase
      end
      J:   nn = {p4[31:28], ins[25:0], 2'b00};
      JAL: begin
        nn = {p4[31:28], ins[25:0], 2'b00};
        wr = 1'b1; wi = 5'd31; res = m_pc + 32'd8;
      end
      BEQ: if (a == b) nn = p4 + (se << 2);
      BNE: if (a != b) nn = p4 + (se << 2);
      ADDIU: begin wr = 1'b1; res = a + se; end
      SLTI:  begin wr = 1'b1; res = ($signed(a) < $signed(se)) ? 1 : 0; end
      SLTIU: begin wr = 1'b1; res = (a < se) ? 32'd1 : 32'd0; end
      ANDI:  begin wr = 1'b1; res = a & ze; end
      ORI:   begin wr = 1'b1; res = a | ze; end
      XORI:  begin wr = 1'b1; res = a ^ ze; end
      LUI:   begin wr = 1'b1; res = {ins[15:0], 16'h0}; end
      LW:    begin wr = 1'b1; res = m_mem[ea[7:2]]; end
      SW:    m_mem[ea[7:2]] = b;
      default: ;
    endcase
    if (wr && wi != 5'd0) m_gpr[wi] = res;
    m_pc  = m_npc;
    m_npc = nn;
    if (m_pc == 32'h0) m_halt = 1'b1;
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
    if (clk_enable && !m_halt) model_step();
    check("pc", instr_address, m_pc);
    check("v0", register_v0, m_gpr[2]);
    check("active", {31'd0, active}, {31'd0, !m_halt});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_pc", instr_address, RV);
    check("rst_v0", register_v0, 32'h0);
    check("rst_active", {31'd0, active}, 32'd1);
  endtask

  task automatic run_to_halt(input int max, output int cyc);
    cyc = 0;
    while (!m_halt && cyc < max) begin
      tick_check();
      cyc++;
    end
    if (!m_halt) check("timeout_active", {31'd0, active}, 32'd0);
    for (int i = 0; i < 2; i++) tick_check();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 64; i++) begin
      ram[i] <= 32'h0;
      m_mem[i] = 32'h0;
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] sv_pc, sv_v0, rv;
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    clk_enable = 1'b1;
    clear_rom();
    clear_ram();

    // 1: basic ALU then halt via JR $0
    rom[0] = ri(ADDIU, 0, 2, 16'd5);
    rom[1] = rr(0, 0, 0, 0, F_JR);
    do_reset();
    tick_check();
    check("t1_v0", register_v0, 32'd5);
    run_to_halt(50, cyc);
    check("t1_cycles", cyc, 32'd2);
    check("t1_halt", {31'd0, active}, 32'd0);

    // 2: load word
    clear_rom();
    clear_ram();
    ram[1] <= 32'h1234_5678;
    m_mem[1] = 32'h1234_5678;
    rom[0] = ri(LW, 0, 2, 16'd4);
    rom[1] = rr(0, 0, 0, 0, F_JR);
    do_reset();
    check("t2_rd", {31'd0, data_read}, 32'd1);
    check("t2_wr", {31'd0, data_write}, 32'd0);
    check("t2_addr", data_address, 32'd4);
    run_to_halt(50, cyc);
    check("t2_v0", register_v0, 32'h1234_5678);
    check("t2_halt_rd", {31'd0, data_read}, 32'd0);

    // 3: LUI/ORI, store then load back
    clear_rom();
    clear_ram();
    rom[0] = ri(LUI, 0, 3, 16'hDEAD);
    rom[1] = ri(ORI, 3, 3, 16'hBEEF);
    rom[2] = ri(SW, 0, 3, 16'd8);
    rom[3] = ri(LW, 0, 2, 16'd8);
    rom[4] = rr(0, 0, 0, 0, F_JR);
    do_reset();
    tick_check();
    tick_check();
    check("t3_wr", {31'd0, data_write}, 32'd1);
    check("t3_rd", {31'd0, data_read}, 32'd0);
    check("t3_addr", data_address, 32'd8);
    check("t3_wdata", data_writedata, 32'hDEAD_BEEF);
    run_to_halt(50, cyc);
    check("t3_ram2", ram[2], 32'hDEAD_BEEF);
    check("t3_v0", register_v0, 32'hDEAD_BEEF);

    // 4: taken branch, delay slot executes, next one skipped
    clear_rom();
    rom[0] = ri(BEQ, 0, 0, 16'd2);
    rom[1] = ri(ADDIU, 0, 2, 16'd1);
    rom[2] = ri(ADDIU, 2, 2, 16'd10);
    rom[3] = rr(0, 0, 0, 0, F_JR);
    do_reset();
    run_to_halt(50, cyc);
    check("t4_v0", register_v0, 32'd1);

    // 5: JAL link value, then JALR link into delay slot
    clear_rom();
    rom[0] = {JAL, 26'h3F0_0004};
    rom[4] = rr(31, 0, 2, 0, F_ADDU);
    rom[5] = rr(0, 0, 5, 0, F_JALR);
    rom[6] = rr(5, 0, 2, 0, F_ADDU);
    do_reset();
    for (int i = 0; i < 3; i++) tick_check();
    check("t5_jal", register_v0, 32'hBFC0_0008);
    run_to_halt(50, cyc);
    check("t5_jalr", register_v0, 32'hBFC0_001C);

    // 6: clock-enable hold, then reset while still disabled
    clear_rom();
    clear_ram();
    rom[0] = ri(ADDIU, 0, 2, 16'd7);
    rom[1] = ri(SW, 0, 2, 16'd0);
    rom[2] = ri(ADDIU, 2, 2, 16'd1);
    rom[3] = rr(0, 0, 0, 0, F_JR);
    do_reset();
    tick_check();
    sv_pc = instr_address;
    sv_v0 = register_v0;
    clk_enable = 1'b0;
    #1;
    check("t6_wr_gated", {31'd0, data_write}, 32'd0);
    for (int i = 0; i < 5; i++) tick_check();
    check("t6_pc_hold", instr_address, RV + 32'd4);
    check("t6_v0_hold", register_v0, 32'd7);
    check("t6_ram_hold", ram[0], 32'd0);
    do_reset();
    clk_enable = 1'b1;

    // Random programs with random clock-enable gaps
    for (int p = 0; p < 20; p++) begin
      int len;
      len = 16;
      clear_rom();
      for (int i = 0; i < 64; i++) begin
        rv = $urandom;
        ram[i] <= rv;
        m_mem[i] = rv;
      end
      for (int i = 0; i < len; i++) begin
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm, addr;
        int sel;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = ($urandom_range(0, 2) == 0) ? 5'd2 : 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        addr = 16'($urandom_range(0, 31) * 4);
        sel = $urandom_range(0, 20);
        if (sel >= 19 && !(i % 2 == 0 && i <= len - 5)) sel = 9;
        case (sel)
          0:  rom[i] = ri(ADDIU, rs, rd, imm);
          1:  rom[i] = ri(ANDI, rs, rd, imm);
          2:  rom[i] = ri(ORI, rs, rd, imm);
          3:  rom[i] = ri(XORI, rs, rd, imm);
          4:  rom[i] = ri(SLTI, rs, rd, imm);
          5:  rom[i] = ri(SLTIU, rs, rd, imm);
          6:  rom[i] = ri(LUI, 0, rd, imm);
          7:  rom[i] = ri(LW, 0, rd, addr);
          8:  rom[i] = ri(SW, 0, rt, addr);
          9:  rom[i] = rr(rs, rt, rd, 0, F_ADDU);
          10: rom[i] = rr(rs, rt, rd, 0, F_SUBU);
          11: rom[i] = rr(rs, rt, rd, 0, F_AND);
          12: rom[i] = rr(rs, rt, rd, 0, F_OR);
          13: rom[i] = rr(rs, rt, rd, 0, F_XOR);
          14: rom[i] = rr(rs, rt, rd, 0, F_SLT);
          15: rom[i] = rr(rs, rt, rd, 0, F_SLTU);
          16: rom[i] = rr(0, rt, rd, imm[4:0], F_SLL);
          17: rom[i] = rr(0, rt, rd, imm[4:0], F_SRL);
          18: rom[i] = rr(0, rt, rd, imm[4:0], F_SRA);
          19: rom[i] = ri(BEQ, rs, rt, 16'($urandom_range(1, 3)));
          default: rom[i] = ri(BNE, rs, rt, 16'($urandom_range(1, 3)));
        endcase
      end
      for (int k = 1; k < 8; k++)
        rom[len + k - 1] = ri(SW, 0, 5'(k), 16'((40 + k) * 4));
      rom[len + 7] = rr(0, 0, 0, 0, F_JR);
      do_reset();
      cyc = 0;
      while (!m_halt && cyc < 200) begin
        clk_enable = ($urandom_range(0, 4) != 0);
        tick_check();
        cyc++;
      end
      clk_enable = 1'b1;
      if (!m_halt) check("rnd_timeout", {31'd0, active}, 32'd0);
      tick_check();
      for (int i = 0; i < 64; i++) check("rnd_ram", ram[i], m_mem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
